// File: rtl/keycode_repeat_mapper_pkg.sv
// keycode_pkg: keycode constants, command encodings, FSM states and the keycode decoder.
package keycode_pkg;
    typedef enum logic [2:0] {
        CUR_NONE  = 3'b000,
        CUR_LEFT  = 3'b001,
        CUR_RIGHT = 3'b010,
        CUR_UP    = 3'b011,
        CUR_DOWN  = 3'b100
    } cursor_e;
    typedef enum logic [1:0] {
        EDIT_NONE = 2'b00,
        EDIT_INC  = 2'b01,
        EDIT_DEC  = 2'b10,
        EDIT_DEL  = 2'b11
    } edit_e;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;
    typedef struct packed {
        logic    valid;
        cursor_e cursor;
        edit_e   edit;
    } key_cmd_t;
    localparam logic [7:0] KC_W        = 8'h1A;
    localparam logic [7:0] KC_A        = 8'h04;
    localparam logic [7:0] KC_S        = 8'h16;
    localparam logic [7:0] KC_D        = 8'h07;
    localparam logic [7:0] KC_I        = 8'h0C;
    localparam logic [7:0] KC_K        = 8'h0E;
    localparam logic [7:0] KC_P        = 8'h13;
    localparam logic [7:0] KC_ROLLOVER = 8'h01;
    function automatic key_cmd_t decode_key(input logic [7:0] code);
        key_cmd_t c;
        c = '{valid: 1'b1, cursor: CUR_NONE, edit: EDIT_NONE};
        case (code)
            KC_W:    c.cursor = CUR_UP;
            KC_A:    c.cursor = CUR_LEFT;
            KC_S:    c.cursor = CUR_DOWN;
            KC_D:    c.cursor = CUR_RIGHT;
            KC_I:    c.edit = EDIT_INC;
            KC_K:    c.edit = EDIT_DEC;
            KC_P:    c.edit = EDIT_DEL;
            default: c.valid = 1'b0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/keycode_repeat_mapper_if.sv
// keycode_repeat_mapper_if: valid/ready command channel toward the editor FSM.
interface keycode_repeat_mapper_if;
    import keycode_pkg::*;
    logic    cmd_valid;
    logic    cmd_ready;
    cursor_e cmd_cursor;
    edit_e   cmd_edit;
    logic    cmd_repeat;
    logic    cmd_overrun;
    modport master (output cmd_valid, cmd_cursor, cmd_edit, cmd_repeat, cmd_overrun, input cmd_ready);
    modport slave (input cmd_valid, cmd_cursor, cmd_edit, cmd_repeat, cmd_overrun, output cmd_ready);
endinterface

// File: rtl/keycode_repeat_mapper_timer.sv
// typematic_timer: loadable down-counter with a zero flag; holds when neither load nor dec.
module typematic_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/keycode_repeat_mapper.sv
// keycode_repeat_mapper: scans a boot-report keycode vector, maps WASD/IKP to editor
// commands with typematic repeat, and offers them through a one-deep valid/ready register.
module keycode_repeat_mapper
    import keycode_pkg::*;
#(
    parameter int NUM_KEYS     = 6,
    parameter int DELAY_CYCLES = 25_000_000,
    parameter int RATE_CYCLES  = 5_000_000,
    localparam int CNT_W = $clog2(DELAY_CYCLES > RATE_CYCLES ? DELAY_CYCLES : RATE_CYCLES)
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic [8*NUM_KEYS-1:0]   keycodes,
    keycode_repeat_mapper_if.master cmd
);
    key_cmd_t         slot_cmd [NUM_KEYS];
    key_cmd_t         sel;
    logic [7:0]       sel_code;
    logic [7:0]       active;
    logic             rollover;
    state_e           state, state_n;
    logic             ev, ev_rpt, t_load, t_dec, t_zero;
    logic [CNT_W-1:0] t_val;
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_dec
        assign slot_cmd[g] = decode_key(keycodes[8*g +: 8]);
    end
    // Downward scan so the lowest-index mapped slot wins.
    always_comb begin
        sel      = '0;
        sel_code = '0;
        rollover = 1'b1;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            rollover = rollover & (keycodes[8*i +: 8] == KC_ROLLOVER);
            if (slot_cmd[i].valid) begin
                sel      = slot_cmd[i];
                sel_code = keycodes[8*i +: 8];
            end
        end
    end
    always_comb begin
        state_n = state;
        ev      = 1'b0;
        ev_rpt  = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_val   = CNT_W'(DELAY_CYCLES - 1);
        if (!rollover) begin
            if (state == IDLE) begin
                if (sel.valid) begin
                    ev      = 1'b1;
                    t_load  = 1'b1;
                    state_n = DELAY;
                end
            end else if (!sel.valid) begin
                state_n = IDLE;
            end else if (sel_code != active) begin
                ev     = 1'b1;
                t_load = 1'b1;
            end else if (t_zero) begin
                ev      = 1'b1;
                ev_rpt  = 1'b1;
                t_load  = 1'b1;
                t_val   = CNT_W'(RATE_CYCLES - 1);
                state_n = REPEAT;
            end else begin
                t_dec = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            active <= '0;
        end else begin
            state <= state_n;
            if (ev && !ev_rpt) active <= sel_code;
        end
    end
    typematic_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .load     (t_load),
        .dec      (t_dec),
        .load_val (t_val),
        .zero     (t_zero)
    );
    // Repeats keep their own cadence; a full register drops the event instead of stalling.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cmd.cmd_valid   <= 1'b0;
            cmd.cmd_cursor  <= CUR_NONE;
            cmd.cmd_edit    <= EDIT_NONE;
            cmd.cmd_repeat  <= 1'b0;
            cmd.cmd_overrun <= 1'b0;
        end else begin
            cmd.cmd_overrun <= ev && cmd.cmd_valid && !cmd.cmd_ready;
            if (ev && (!cmd.cmd_valid || cmd.cmd_ready)) begin
                cmd.cmd_valid  <= 1'b1;
                cmd.cmd_cursor <= sel.cursor;
                cmd.cmd_edit   <= sel.edit;
                cmd.cmd_repeat <= ev_rpt;
            end else if (cmd.cmd_ready) begin
                cmd.cmd_valid <= 1'b0;
            end
        end
    end
endmodule
